// File: rtl/imager_pkg.sv
// Shared types and widths for the imager capture path.
// Widths here match the sim imager's pixel and geometry counters.
package imager_pkg;

    localparam int DATA_W  = 10;
    localparam int ROW_W   = 12;
    localparam int COL_W   = 12;
    localparam int FIFO_AW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [DATA_W-1:0] pixel;
    } cap_entry_t;

endpackage

// File: rtl/imager_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// Head data reads as zero while empty so the stream outputs idle at 0.
module capture_fifo #(
    parameter int W  = 12,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_do_push)
                               - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/imager_capture.sv
// Imager capture: frames fv/lv/dat into a tagged valid/ready pixel stream,
// buffers it, and measures frame geometry with sticky error flags.
module imager_capture
    import imager_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_W,
    parameter int NUM_ROWS_WIDTH  = ROW_W,
    parameter int NUM_COLS_WIDTH  = COL_W,
    parameter int FIFO_DEPTH_LOG2 = FIFO_AW
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     dat,
    input  logic                      fv,
    input  logic                      lv,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_done,
    output logic [NUM_ROWS_WIDTH-1:0] rows_seen,
    output logic [NUM_COLS_WIDTH-1:0] cols_seen,
    output logic                      geometry_err,
    output logic                      overflow,
    input  logic                      err_clr
);

    localparam int EW = DATA_WIDTH + 2;

    cap_state_t                r_state;
    cap_state_t                w_state_nxt;
    logic                      r_fv_d;
    logic                      r_lv_d;
    logic                      r_hold_valid;
    logic [DATA_WIDTH-1:0]     r_hold_data;
    logic                      r_sof_pend;
    logic [NUM_COLS_WIDTH-1:0] r_col_cnt;
    logic [NUM_COLS_WIDTH-1:0] r_len0;
    logic [NUM_ROWS_WIDTH-1:0] r_row_cnt;

    logic                      w_fv_lv;
    logic                      w_fv_rise;
    logic                      w_fv_fall;
    logic                      w_start;
    logic                      w_cap;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_ovf;
    logic                      w_line_end;
    logic                      w_geo_set;
    logic                      w_done;
    logic [NUM_ROWS_WIDTH-1:0] w_row_nxt;
    logic [NUM_COLS_WIDTH-1:0] w_len0_nxt;
    logic [EW-1:0]             w_fifo_in;
    logic [EW-1:0]             w_fifo_out;

    assign w_fv_lv   = fv && lv;
    assign w_fv_rise = fv && !r_fv_d;
    assign w_fv_fall = !fv && r_fv_d;
    assign w_start   = enable && (r_state == ST_IDLE) && w_fv_rise;
    assign w_cap     = enable && w_fv_lv
                    && ((r_state == ST_ACTIVE) || w_start);
    assign w_push    = enable && (r_state == ST_ACTIVE) && r_hold_valid;
    assign w_pop     = out_valid && out_ready;
    assign w_ovf     = w_push && w_full && !w_pop;
    assign w_fifo_in = {r_sof_pend, !w_fv_lv, r_hold_data};

    // Line end is the first cycle the gated line-valid drops.
    assign w_line_end = enable && (r_state == ST_ACTIVE)
                     && r_lv_d && !w_fv_lv;
    assign w_row_nxt  = w_line_end
                      ? r_row_cnt + NUM_ROWS_WIDTH'(~&r_row_cnt)
                      : r_row_cnt;
    assign w_len0_nxt = (w_line_end && (r_row_cnt == '0))
                      ? r_col_cnt : r_len0;
    assign w_geo_set  = w_line_end && (r_row_cnt != '0)
                     && (r_col_cnt != r_len0);
    assign w_done     = enable && (r_state == ST_ACTIVE)
                     && w_fv_fall && !w_ovf;

    capture_fifo #(
        .W  (EW),
        .AW (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (!enable),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_sof   = w_fifo_out[EW-1];
    assign out_eol   = w_fifo_out[EW-2];
    assign out_data  = w_fifo_out[DATA_WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fv_rise) w_state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_fv_fall)  w_state_nxt = ST_IDLE;
                    else if (w_ovf) w_state_nxt = ST_DROP;
                end
                ST_DROP: begin
                    if (w_fv_fall) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_fv_d       <= 1'b0;
            r_lv_d       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_sof_pend   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fv_d       <= fv;
            r_lv_d       <= w_fv_lv;
            r_hold_valid <= w_cap;
            if (w_cap) begin
                r_hold_data <= dat;
            end
            if (w_start) begin
                r_sof_pend <= 1'b1;
            end else if (w_push) begin
                r_sof_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_len0       <= '0;
            rows_seen    <= '0;
            cols_seen    <= '0;
            frame_done   <= 1'b0;
            geometry_err <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (w_start || w_line_end) begin
                r_col_cnt <= NUM_COLS_WIDTH'(w_cap);
            end else if (w_cap) begin
                r_col_cnt <= r_col_cnt + NUM_COLS_WIDTH'(~&r_col_cnt);
            end
            r_row_cnt  <= w_start ? '0 : w_row_nxt;
            r_len0     <= w_start ? '0 : w_len0_nxt;
            frame_done <= w_done;
            if (w_done) begin
                rows_seen <= w_row_nxt;
                cols_seen <= w_len0_nxt;
            end
            if (w_geo_set)    geometry_err <= 1'b1;
            else if (err_clr) geometry_err <= 1'b0;
            if (w_ovf)        overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
        end
    end

endmodule
